// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- fetch-stage program counter for the pipelined MIPS core.
//
// Holds the word-aligned fetch address and picks the next one, highest
// priority first: reset vector, exception vector, EX-stage redirect, stall
// hold, predecoded call target, return-address-stack pop, sequential +1.
//
// Optional feature macro: PC_RAS_EN
//   defined   -> a circular return-address stack predicts `jr $ra` targets.
//   undefined -> no stack; pred_ret is ignored, pred_call only redirects,
//                pc_from_ras=0, ras_empty=1, ras_full=0 constantly.
//
// Parameters:
//   ADDR_W    byte address width; pc holds bits [ADDR_W-1:2]
//   RESET_VEC byte address loaded on reset
//   EXC_VEC   byte address loaded on exception entry
//   RAS_DEPTH return-address-stack entries (power of two, >= 2)
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-low reset
//   stall          in   hold pc (hazard unit)
//   redirect_valid in   EX resolved branch/jump/mispredict
//   redirect_pc    in   redirect target, word address
//   exc_valid      in   exception entry
//   pred_call      in   predecode: jal/jalr with known target
//   call_target    in   predecoded call target, word address
//   pred_ret       in   predecode: jr $ra
//   pc             out  current fetch word address (registered)
//   pc_from_ras    out  current pc came from a stack pop
//   ras_empty      out  stack holds no entries (registered)
//   ras_full       out  stack holds RAS_DEPTH entries (registered)
// -----------------------------------------------------------------------------
module pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_4180,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-3:0] redirect_pc,
  input  logic              exc_valid,
  input  logic              pred_call,
  input  logic [ADDR_W-3:0] call_target,
  input  logic              pred_ret,
  output logic [ADDR_W-3:0] pc,
  output logic              pc_from_ras,
  output logic              ras_empty,
  output logic              ras_full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [ADDR_W-3:0] RST_WORD = RESET_VEC[ADDR_W-1:2];
  localparam logic [ADDR_W-3:0] EXC_WORD = EXC_VEC[ADDR_W-1:2];

  logic [ADDR_W-3:0] r_pc;
  logic [ADDR_W-3:0] w_pc_inc;
  logic [ADDR_W-3:0] w_ras_top;
  logic              w_pop;

  // Predecode inputs only act when nothing of higher priority claims the edge.
  logic w_run;
  assign w_run    = ~exc_valid & ~redirect_valid & ~stall;
  assign w_pc_inc = r_pc + 1'b1;  // wraps modulo 2^(ADDR_W-2)

`ifdef PC_RAS_EN
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-3:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ptr;          // next slot to write; top is r_ptr-1
  logic [CNT_W-1:0]  r_cnt;
  logic              r_pc_from_ras;
  logic              r_ras_empty;
  logic              r_ras_full;
  logic [PTR_W-1:0]  w_top_idx;
  logic              w_push;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  assign w_top_idx = r_ptr - 1'b1;
  assign w_ras_top = r_ras[w_top_idx];
  assign w_push    = rst & w_run & pred_call;
  // A call in the same cycle wins, so the return is dropped.
  assign w_pop     = rst & w_run & ~pred_call & pred_ret & ~r_ras_empty;

  always_comb begin
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    if (exc_valid) begin
      w_ptr_nxt = '0;
      w_cnt_nxt = '0;
    end else if (w_push) begin
      // When full, the slot at r_ptr is the oldest entry and is overwritten.
      w_ptr_nxt = r_ptr + 1'b1;
      w_cnt_nxt = (r_cnt == DEPTH_C) ? r_cnt : r_cnt + 1'b1;
    end else if (w_pop) begin
      w_ptr_nxt = w_top_idx;
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_ras_empty <= 1'b1;
      r_ras_full  <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ras_empty <= (w_cnt_nxt == '0);
      r_ras_full  <= (w_cnt_nxt == DEPTH_C);
    end
  end

  // Stack storage carries no reset; validity is tracked by r_cnt.
  always_ff @(posedge clk) begin
    if (w_push) r_ras[r_ptr] <= w_pc_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc_from_ras <= 1'b0;
    end else if (exc_valid || redirect_valid || !stall) begin
      r_pc_from_ras <= w_pop;
    end
  end

  assign pc_from_ras = r_pc_from_ras;
  assign ras_empty   = r_ras_empty;
  assign ras_full    = r_ras_full;
`else
  // Return prediction is disabled: pred_ret never takes effect.
  assign w_pop       = pred_ret & 1'b0;
  assign w_ras_top   = '0;
  assign pc_from_ras = 1'b0;
  assign ras_empty   = 1'b1;
  assign ras_full    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= RST_WORD;
    end else if (exc_valid) begin
      r_pc <= EXC_WORD;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (!stall) begin
      if (pred_call)  r_pc <= call_target;
      else if (w_pop) r_pc <= w_ras_top;
      else            r_pc <= w_pc_inc;
    end
  end

  assign pc = r_pc;

endmodule
